phivers_link_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one credit-based link (tx/cr/eop/32-bit data) among N_PORTS requesters. It sits in front of a link instance at a router output or local injection point. It grants one requester at a time and holds that grant for the whole packet, releasing it only on the EOP flit transfer, so packets are never interleaved on the link.

---
 rtl/phivers_link_pkg.sv | 13 +
 rtl/phivers_link_arbiter_if.sv | 32 +++
 rtl/phivers_link_arbiter_rr_picker.sv | 28 ++
 rtl/phivers_link_arbiter.sv | 80 ++++++++
 tb/tb_phivers_link_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phivers_link_pkg.sv
// Shared types for the phivers link fabric: flit width, flit type and arbiter state encoding.
package phivers_link_pkg;

  localparam int unsigned FLIT_W = 32;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/phivers_link_arbiter_if.sv
// Bundle of requester-side and link-side signals for the link arbiter.
// master: the arbiter; slave: the requesters plus the downstream link.
interface phivers_link_arbiter_if #(
  parameter int unsigned N_PORTS = 4
) ();
  import phivers_link_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0]         req_tx_i;
  logic [N_PORTS-1:0]         req_cr_o;
  logic [N_PORTS-1:0]         req_eop_i;
  flit_t [N_PORTS-1:0]        req_data_i;
  logic                       tx_o;
  logic                       cr_i;
  logic                       eop_o;
  flit_t                      data_o;
  logic [IDX_W-1:0]           grant_o;
  logic                       busy_o;
  logic [31:0]                pkt_cnt_o;

  modport master (
    input  req_tx_i, req_eop_i, req_data_i, cr_i,
    output req_cr_o, tx_o, eop_o, data_o, grant_o, busy_o, pkt_cnt_o
  );

  modport slave (
    output req_tx_i, req_eop_i, req_data_i, cr_i,
    input  req_cr_o, tx_o, eop_o, data_o, grant_o, busy_o, pkt_cnt_o
  );

endinterface

// File: rtl/phivers_link_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned N_PORTS = 4
) (
  input  logic [N_PORTS-1:0]         req_i,
  input  logic [$clog2(N_PORTS)-1:0] ptr_i,
  output logic                       valid_o,
  output logic [$clog2(N_PORTS)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(N_PORTS);

  always_comb begin : p_pick
    int unsigned k;
    valid_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    // Walk from farthest to nearest so the nearest requester after ptr_i wins.
    for (int i = N_PORTS; i > 0; i--) begin
      k = (32'(ptr_i) + 32'(i)) % N_PORTS;
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/phivers_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one credit-based link among N_PORTS requesters.
// A grant is held from the first flit until the EOP flit transfers, so packets never interleave.
module phivers_link_arbiter
  import phivers_link_pkg::*;
#(
  parameter int unsigned N_PORTS = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  phivers_link_arbiter_if.master link
);

  localparam int unsigned IDX_W = $clog2(N_PORTS);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_ptr;
  logic [31:0]      r_pkt_cnt;

  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_xfer;

  rr_picker #(
    .N_PORTS (N_PORTS)
  ) u_picker (
    .req_i   (link.req_tx_i),
    .ptr_i   (r_ptr),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  // Zero-latency pass-through from the owner; everything is 0 outside BUSY.
  always_comb begin
    link.tx_o     = 1'b0;
    link.eop_o    = 1'b0;
    link.data_o   = '0;
    link.req_cr_o = '0;
    link.busy_o   = 1'b0;
    link.grant_o  = '0;
    if (r_state == ARB_BUSY) begin
      link.tx_o              = link.req_tx_i[r_grant];
      link.eop_o             = link.req_eop_i[r_grant];
      link.data_o            = link.req_data_i[r_grant];
      link.req_cr_o[r_grant] = link.cr_i;
      link.busy_o            = 1'b1;
      link.grant_o           = r_grant;
    end
  end

  assign w_xfer         = link.tx_o & link.cr_i;
  assign link.pkt_cnt_o = r_pkt_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= IDX_W'(N_PORTS - 1);
      r_grant   <= '0;
      r_pkt_cnt <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_idx;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_xfer && link.eop_o) begin
            r_ptr     <= r_grant;
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_state   <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phivers_link_arbiter.sv
// Directed self-checking bench for phivers_link_arbiter (N_PORTS = 4).
module tb_phivers_link_arbiter;
  import phivers_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  phivers_link_arbiter_if #(.N_PORTS(4)) link ();

  phivers_link_arbiter #(
    .N_PORTS (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .link  (link)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    link.req_tx_i   = '0;
    link.req_eop_i  = '0;
    link.req_data_i = '0;
    link.cr_i       = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    link.req_tx_i = 4'b1111;  // reset must win over pending requests
    rst = 1'b1;
    step();
    step();
    settle();
    checks++; if (link.busy_o !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %0h exp 0", link.busy_o); end
    checks++; if (link.tx_o !== 1'b0) begin errors++;
      $display("FAIL reset_tx got %0h exp 0", link.tx_o); end
    checks++; if (link.data_o !== 32'h0) begin errors++;
      $display("FAIL reset_data got %0h exp 0", link.data_o); end
    checks++; if (link.req_cr_o !== 4'b0000) begin errors++;
      $display("FAIL reset_req_cr got %b exp 0000", link.req_cr_o); end
    checks++; if (link.grant_o !== 2'd0) begin errors++;
      $display("FAIL reset_grant got %0d exp 0", link.grant_o); end
    checks++; if (link.pkt_cnt_o !== 32'd0) begin errors++;
      $display("FAIL reset_pkt_cnt got %0d exp 0", link.pkt_cnt_o); end
    rst = 1'b0;
    clear_inputs();
  endtask

  // Port 1 sends a 3-flit packet A0..A2 with credit always available.
  task automatic test_single_packet();
    step();
    link.req_tx_i[1]   = 1'b1;
    link.req_data_i[1] = 32'hA0;
    settle();
    checks++; if (link.tx_o !== 1'b0 || link.busy_o !== 1'b0) begin errors++;
      $display("FAIL sp_arb_cycle got tx=%0h busy=%0h exp 0 0", link.tx_o, link.busy_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      link.req_data_i[1] = 32'hA0 + 32'(i);
      link.req_eop_i[1]  = (i == 2);
      settle();
      checks++;
      if (link.tx_o !== 1'b1 || link.data_o !== 32'hA0 + 32'(i) || link.grant_o !== 2'd1 ||
          link.req_cr_o !== 4'b0010 || link.eop_o !== (i == 2)) begin
        errors++;
        $display("FAIL sp_flit%0d got tx=%0h data=%0h grant=%0d cr=%b eop=%0h exp 1 %0h 1 0010 %0h",
                 i, link.tx_o, link.data_o, link.grant_o, link.req_cr_o, link.eop_o,
                 32'hA0 + 32'(i), (i == 2));
      end
    end
    step();
    clear_inputs();
    settle();
    checks++; if (link.busy_o !== 1'b0 || link.pkt_cnt_o !== 32'd1) begin errors++;
      $display("FAIL sp_done got busy=%0h pkt=%0d exp 0 1", link.busy_o, link.pkt_cnt_o); end
  endtask

  // All ports stream single-flit packets: grants 0,1,2,3,0 with a bubble between.
  task automatic test_round_robin();
    logic [1:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    link.req_tx_i  = 4'b1111;
    link.req_eop_i = 4'b1111;
    for (int k = 0; k < 4; k++) link.req_data_i[k] = 32'hB0 + 32'(k);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      settle();
      if (c % 2 == 0) begin
        checks++; if (link.busy_o !== 1'b0 || link.tx_o !== 1'b0) begin errors++;
          $display("FAIL rr_bubble%0d got busy=%0h tx=%0h exp 0 0", c, link.busy_o, link.tx_o); end
      end else begin
        exp_g = 2'(((c - 1) / 2) % 4);
        checks++;
        if (link.busy_o !== 1'b1 || link.grant_o !== exp_g || link.data_o !== 32'hB0 + 32'(exp_g))
        begin
          errors++;
          $display("FAIL rr_grant%0d got busy=%0h grant=%0d data=%0h exp 1 %0d %0h", c,
                   link.busy_o, link.grant_o, link.data_o, exp_g, 32'hB0 + 32'(exp_g));
        end
      end
    end
    step();
    clear_inputs();
    settle();
    checks++; if (link.pkt_cnt_o !== 32'd5) begin errors++;
      $display("FAIL rr_pkt_cnt got %0d exp 5", link.pkt_cnt_o); end
  endtask

  // Port 2 packet C0..C2 with five credit-stall cycles on the second flit.
  task automatic test_credit_stall();
    step();
    link.req_tx_i[2]   = 1'b1;
    link.req_data_i[2] = 32'hC0;
    settle();
    step();
    settle();
    checks++; if (link.grant_o !== 2'd2 || link.req_cr_o !== 4'b0100) begin errors++;
      $display("FAIL cs_first got grant=%0d cr=%b exp 2 0100", link.grant_o, link.req_cr_o); end
    step();
    link.req_data_i[2] = 32'hC1;
    link.cr_i          = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) step();
      settle();
      checks++;
      if (link.tx_o !== 1'b1 || link.req_cr_o !== 4'b0000 || link.grant_o !== 2'd2 ||
          link.busy_o !== 1'b1 || link.data_o !== 32'hC1) begin
        errors++;
        $display("FAIL cs_stall%0d got tx=%0h cr=%b grant=%0d busy=%0h data=%0h exp 1 0000 2 1 c1",
                 s, link.tx_o, link.req_cr_o, link.grant_o, link.busy_o, link.data_o);
      end
    end
    step();
    link.cr_i = 1'b1;
    settle();
    checks++; if (link.data_o !== 32'hC1 || link.req_cr_o !== 4'b0100) begin errors++;
      $display("FAIL cs_resume got data=%0h cr=%b exp c1 0100", link.data_o, link.req_cr_o); end
    step();
    link.req_data_i[2] = 32'hC2;
    link.req_eop_i[2]  = 1'b1;
    settle();
    checks++; if (link.data_o !== 32'hC2 || link.eop_o !== 1'b1) begin errors++;
      $display("FAIL cs_last got data=%0h eop=%0h exp c2 1", link.data_o, link.eop_o); end
    step();
    clear_inputs();
    settle();
    checks++; if (link.busy_o !== 1'b0 || link.pkt_cnt_o !== 32'd6) begin errors++;
      $display("FAIL cs_done got busy=%0h pkt=%0d exp 0 6", link.busy_o, link.pkt_cnt_o); end
  endtask

  // Port 0 owns the link; port 3 arrives mid-packet and must wait for the EOP.
  task automatic test_no_preempt();
    step();
    link.req_tx_i[0]   = 1'b1;
    link.req_data_i[0] = 32'hD0;
    settle();
    for (int i = 0; i < 3; i++) begin
      step();
      link.req_data_i[0] = 32'hD0 + 32'(i);
      link.req_eop_i[0]  = (i == 2);
      if (i == 0) begin
        link.req_tx_i[3]   = 1'b1;
        link.req_eop_i[3]  = 1'b1;
        link.req_data_i[3] = 32'hE0;
      end
      settle();
      checks++;
      if (link.grant_o !== 2'd0 || link.req_cr_o !== 4'b0001 || link.data_o !== 32'hD0 + 32'(i))
      begin
        errors++;
        $display("FAIL np_hold%0d got grant=%0d cr=%b data=%0h exp 0 0001 %0h", i,
                 link.grant_o, link.req_cr_o, link.data_o, 32'hD0 + 32'(i));
      end
    end
    step();
    link.req_tx_i[0]  = 1'b0;
    link.req_eop_i[0] = 1'b0;
    settle();
    checks++; if (link.busy_o !== 1'b0 || link.req_cr_o !== 4'b0000) begin errors++;
      $display("FAIL np_bubble got busy=%0h cr=%b exp 0 0000", link.busy_o, link.req_cr_o); end
    step();
    settle();
    checks++;
    if (link.grant_o !== 2'd3 || link.data_o !== 32'hE0 || link.req_cr_o !== 4'b1000) begin
      errors++;
      $display("FAIL np_next got grant=%0d data=%0h cr=%b exp 3 e0 1000",
               link.grant_o, link.data_o, link.req_cr_o);
    end
    step();
    clear_inputs();
    settle();
    checks++; if (link.pkt_cnt_o !== 32'd8) begin errors++;
      $display("FAIL np_pkt_cnt got %0d exp 8", link.pkt_cnt_o); end
  endtask

  // Reset during the second flit; the pointer must return so port 0 beats port 2.
  task automatic test_reset_mid_packet();
    step();
    link.req_tx_i[0]   = 1'b1;
    link.req_eop_i[0]  = 1'b1;
    link.req_data_i[0] = 32'hF0;
    settle();
    step();
    settle();
    checks++; if (link.grant_o !== 2'd0) begin errors++;
      $display("FAIL rm_pre_grant got %0d exp 0", link.grant_o); end
    step();
    clear_inputs();
    link.req_tx_i[1]   = 1'b1;
    link.req_data_i[1] = 32'h10;
    settle();
    step();
    settle();
    checks++; if (link.grant_o !== 2'd1 || link.data_o !== 32'h10) begin errors++;
      $display("FAIL rm_owner got grant=%0d data=%0h exp 1 10", link.grant_o, link.data_o); end
    step();
    link.req_data_i[1] = 32'h11;
    rst = 1'b1;
    settle();
    step();
    rst = 1'b0;
    clear_inputs();
    link.req_tx_i      = 4'b0101;
    link.req_eop_i     = 4'b0101;
    link.req_data_i[0] = 32'h20;
    link.req_data_i[2] = 32'h22;
    settle();
    checks++;
    if (link.tx_o !== 1'b0 || link.busy_o !== 1'b0 || link.pkt_cnt_o !== 32'd0 ||
        link.data_o !== 32'h0) begin
      errors++;
      $display("FAIL rm_after got tx=%0h busy=%0h pkt=%0d data=%0h exp 0 0 0 0",
               link.tx_o, link.busy_o, link.pkt_cnt_o, link.data_o);
    end
    step();
    settle();
    checks++; if (link.grant_o !== 2'd0 || link.data_o !== 32'h20) begin errors++;
      $display("FAIL rm_regrant got grant=%0d data=%0h exp 0 20", link.grant_o, link.data_o); end
    step();
    link.req_tx_i[0]  = 1'b0;
    link.req_eop_i[0] = 1'b0;
    settle();
    checks++; if (link.pkt_cnt_o !== 32'd1 || link.busy_o !== 1'b0) begin errors++;
      $display("FAIL rm_done got pkt=%0d busy=%0h exp 1 0", link.pkt_cnt_o, link.busy_o); end
  endtask

  // Packet counter preloaded to all-ones wraps to zero on the next completion.
  task automatic test_pkt_wrap();
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    step();
    release dut.r_pkt_cnt;
    settle();
    checks++;
    if (link.pkt_cnt_o !== 32'hFFFF_FFFF || link.grant_o !== 2'd2 || link.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pre got pkt=%0h grant=%0d busy=%0h exp ffffffff 2 1",
               link.pkt_cnt_o, link.grant_o, link.busy_o);
    end
    step();
    clear_inputs();
    settle();
    checks++; if (link.pkt_cnt_o !== 32'd0) begin errors++;
      $display("FAIL wrap_cnt got %0h exp 0", link.pkt_cnt_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credit_stall();
    test_no_preempt();
    test_reset_mid_packet();
    test_pkt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
